uart_rx_ext: RTL

Parametrised UART receiver with an oversampled bit-timing engine, configurable frame format (data bits, parity, stop bits), error detection and a multi-word pop FIFO. It sits between the board `rx` pin and the FFT sample-assembly logic. It lets the host link run arbitrary frame formats, and lets downstream logic drain up to N words per clock.

---
 rtl/uart_rx_ext_if.sv | 25 ++
 rtl/uart_rx_ext.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext_if.sv
// FIFO-side bundle of the UART receiver: multi-word head view, pop request and sticky flags.
interface uart_rx_ext_if #(
    parameter int unsigned N         = 4,
    parameter int unsigned DATA_BITS = 8
);
    localparam int unsigned PW = $clog2(N + 1);

    logic [N-1:0][DATA_BITS-1:0] data;
    logic [PW-1:0]               pop;
    logic [PW-1:0]               can_pop;
    logic                        frame_err;
    logic                        parity_err;
    logic                        overrun;
    logic                        err_clr;

    modport slave (
        output data, can_pop, frame_err, parity_err, overrun,
        input  pop, err_clr
    );

    modport master (
        input  data, can_pop, frame_err, parity_err, overrun,
        output pop, err_clr
    );
endinterface

// File: rtl/uart_rx_ext.sv
// UART receiver with oversampled majority-vote bit timing, configurable frame format,
// sticky error flags and a circular FIFO that can release up to N words per clock.
module uart_rx_ext #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned N          = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         rx,
    uart_rx_ext_if.slave bus
);
    localparam int unsigned SAMP = BAUDRATE * OVERSAMPLE;
    localparam int unsigned DIV  = (CLK_FREQ + SAMP / 2) / SAMP;
    localparam int unsigned DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PHW  = $clog2(OVERSAMPLE);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned PW   = $clog2(N + 1);

    localparam logic [DW-1:0]  DivLast  = DW'(DIV - 1);
    localparam logic [PHW-1:0] PhS0     = PHW'(OVERSAMPLE / 2 - 1);
    localparam logic [PHW-1:0] PhS1     = PHW'(OVERSAMPLE / 2);
    localparam logic [PHW-1:0] PhS2     = PHW'(OVERSAMPLE / 2 + 1);
    localparam logic [PHW-1:0] PhLast   = PHW'(OVERSAMPLE - 1);
    localparam logic [3:0]     LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LastStop = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0]  NCnt     = CW'(N);
    localparam logic [CW-1:0]  DepthCnt = CW'(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [1:0]           sync_q;
    logic                 rx_prev_q, rx_s, fall;
    logic [DW-1:0]        div_q;
    logic                 tick, vote, vote_now, bit_end, par_exp;
    state_e               state_q, state_d;
    logic [PHW-1:0]       phase_q, phase_d;
    logic [3:0]           bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, word_q, word_d;
    logic                 bad_q, bad_d, push_q, push_d, perr_set, ferr_set;
    logic                 perr_q, ferr_q, ovr_q;

    logic [DATA_BITS-1:0]        mem_q [DEPTH];
    logic [AW-1:0]               rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]               count_q;
    logic [PW-1:0]               can_pop, pop_eff;
    logic                        push_ok, push_acc;
    logic [N-1:0][DATA_BITS-1:0] head;

    assign rx_s     = sync_q[1];
    assign fall     = rx_prev_q & ~rx_s;
    assign tick     = (div_q == DivLast);
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign vote_now = tick && (phase_q == PhS2);
    assign bit_end  = tick && (phase_q == PhLast);
    assign par_exp  = (PARITY == 1) ? ~^shift_q : ^shift_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            state_q   <= StIdle;
            phase_q   <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            bad_q     <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
            div_q     <= tick ? '0 : div_q + 1'b1;
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            bad_q     <= bad_d;
            push_q    <= push_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        samp_d   = samp_q;
        shift_d  = shift_q;
        word_d   = word_q;
        bad_d    = bad_q;
        push_d   = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        if (state_q != StIdle && tick) begin
            phase_d = bit_end ? '0 : phase_q + 1'b1;
            if (phase_q == PhS0) samp_d[0] = rx_s;
            if (phase_q == PhS1) samp_d[1] = rx_s;
        end
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    phase_d = '0;
                    bit_d   = '0;
                    bad_d   = 1'b0;
                end
            end
            StStart: begin
                if (vote_now && vote) state_d = StIdle;
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (vote_now) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == LastData) begin
                        bit_d   = '0;
                        state_d = (PARITY == 0) ? StStop : StParity;
                    end
                end
            end
            StParity: begin
                if (vote_now && (vote != par_exp)) begin
                    perr_set = 1'b1;
                    bad_d    = 1'b1;
                end
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (vote_now) begin
                    if (!vote) begin
                        ferr_set = 1'b1;
                        bad_d    = 1'b1;
                    end
                    // Frame ends at the last stop vote so a following start edge is not missed.
                    if (bit_q == LastStop) begin
                        state_d = StIdle;
                        push_d  = ~bad_q & vote;
                        word_d  = shift_q;
                    end
                end
                if (bit_end) bit_d = bit_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign can_pop  = (count_q > NCnt) ? PW'(N) : PW'(count_q);
    assign pop_eff  = (bus.pop > can_pop) ? can_pop : bus.pop;
    assign push_ok  = (count_q - CW'(pop_eff)) < DepthCnt;
    assign push_acc = push_q & push_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_q + AW'(pop_eff);
            wr_ptr_q <= wr_ptr_q + AW'(push_acc);
            count_q  <= count_q - CW'(pop_eff) + CW'(push_acc);
            perr_q   <= perr_set | (perr_q & ~bus.err_clr);
            ferr_q   <= ferr_set | (ferr_q & ~bus.err_clr);
            ovr_q    <= (push_q & ~push_ok) | (ovr_q & ~bus.err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= word_q;
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < N; i++) begin
            if (PW'(i) < can_pop) head[i] = mem_q[rd_ptr_q + AW'(i)];
        end
    end

    assign bus.data       = head;
    assign bus.can_pop    = can_pop;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.overrun    = ovr_q;
endmodule
